// File: rtl/run_ctrl.sv
// Run controller for the basic processor: Start/Ack program handshake, start-address load,
// execution gating, saturating performance counters and an optional RUN-cycle watchdog.
module run_ctrl #(
    parameter int AW      = 10,
    parameter int CW      = 16,
    parameter int TMO_CYC = 4096
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [AW-1:0] StartAddr,
    input  logic          Halt,
    input  logic          Retire,
    input  logic          BranchTaken,
    output logic          PcLoad,
    output logic [AW-1:0] PcLoadVal,
    output logic          Run,
    output logic          Ack,
    output logic          Timeout,
    output logic [CW-1:0] CycleCt,
    output logic [CW-1:0] InstCt,
    output logic [CW-1:0] BranchCt,
    output logic          CtOvf
);

    typedef enum logic [2:0] {IDLE, ARM, RUN, DONE, TMO} state_t;

    localparam logic [CW-1:0] CT_MAX  = '1;
    localparam logic [CW-1:0] TMO_VAL = CW'(TMO_CYC);
    // A limit the cycle counter can never reach behaves like a disabled watchdog.
    localparam bit WD_ON = (TMO_CYC > 0) && (longint'(TMO_CYC) <= longint'(CT_MAX));

    state_t        state;
    logic          cyc_full;
    logic          inst_full;
    logic          br_full;
    logic          br_inc;
    logic          wd_hit;
    logic [CW-1:0] cyc_next;

    always_comb begin
        cyc_full  = (CycleCt == CT_MAX);
        inst_full = (InstCt == CT_MAX);
        br_full   = (BranchCt == CT_MAX);
        br_inc    = Retire && BranchTaken;
        cyc_next  = cyc_full ? CycleCt : CycleCt + 1'b1;
        wd_hit    = WD_ON && !Halt && (cyc_next == TMO_VAL);
    end

    // NOTE: all state and outputs are registers updated with non-blocking assignments, so
    // every branch below reads the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            PcLoad    <= 1'b0;
            PcLoadVal <= '0;
            Run       <= 1'b0;
            Ack       <= 1'b0;
            Timeout   <= 1'b0;
            CycleCt   <= '0;
            InstCt    <= '0;
            BranchCt  <= '0;
            CtOvf     <= 1'b0;
        end else if (Start) begin
            // Start arms from every state: first launch, rerun after finish, or abort of a live run.
            state     <= ARM;
            PcLoad    <= 1'b1;
            PcLoadVal <= StartAddr;
            Run       <= 1'b0;
            Ack       <= 1'b0;
            Timeout   <= 1'b0;
            CycleCt   <= '0;
            InstCt    <= '0;
            BranchCt  <= '0;
            CtOvf     <= 1'b0;
        end else begin
            unique case (state)
                ARM: begin
                    state  <= RUN;
                    PcLoad <= 1'b0;
                    Run    <= 1'b1;
                end
                RUN: begin
                    CycleCt <= cyc_next;
                    if (cyc_full) CtOvf <= 1'b1;
                    if (Retire) begin
                        if (inst_full) CtOvf  <= 1'b1;
                        else           InstCt <= InstCt + 1'b1;
                    end
                    if (br_inc) begin
                        if (br_full) CtOvf    <= 1'b1;
                        else         BranchCt <= BranchCt + 1'b1;
                    end
                    // The halting cycle is still counted above; halt outranks the watchdog.
                    if (Halt) begin
                        state <= DONE;
                        Run   <= 1'b0;
                        Ack   <= 1'b1;
                    end else if (wd_hit) begin
                        state   <= TMO;
                        Run     <= 1'b0;
                        Ack     <= 1'b1;
                        Timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: three configurations share one randomized stimulus stream; a run-level
// reference model queues expected results and a monitor checks them at every Ack rise.
module tb_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] start_addr;
    logic       halt;
    logic       retire;
    logic       branch_taken;

    always #5 clk = ~clk;

    logic        a_pcl, a_run, a_ack, a_tmo, a_ovf;
    logic [9:0]  a_pcv;
    logic [15:0] a_cyc, a_inst, a_br;
    logic        w_pcl, w_run, w_ack, w_tmo, w_ovf;
    logic [9:0]  w_pcv;
    logic [15:0] w_cyc, w_inst, w_br;
    logic        s_pcl, s_run, s_ack, s_tmo, s_ovf;
    logic [9:0]  s_pcv;
    logic [3:0]  s_cyc, s_inst, s_br;

    run_ctrl #(.AW(10), .CW(16), .TMO_CYC(4096)) dut_a (
        .Clk(clk), .Reset(rst_n), .Start(start), .StartAddr(start_addr), .Halt(halt),
        .Retire(retire), .BranchTaken(branch_taken), .PcLoad(a_pcl), .PcLoadVal(a_pcv),
        .Run(a_run), .Ack(a_ack), .Timeout(a_tmo), .CycleCt(a_cyc), .InstCt(a_inst),
        .BranchCt(a_br), .CtOvf(a_ovf)
    );

    run_ctrl #(.AW(10), .CW(16), .TMO_CYC(8)) dut_w (
        .Clk(clk), .Reset(rst_n), .Start(start), .StartAddr(start_addr), .Halt(halt),
        .Retire(retire), .BranchTaken(branch_taken), .PcLoad(w_pcl), .PcLoadVal(w_pcv),
        .Run(w_run), .Ack(w_ack), .Timeout(w_tmo), .CycleCt(w_cyc), .InstCt(w_inst),
        .BranchCt(w_br), .CtOvf(w_ovf)
    );

    run_ctrl #(.AW(10), .CW(4), .TMO_CYC(0)) dut_s (
        .Clk(clk), .Reset(rst_n), .Start(start), .StartAddr(start_addr), .Halt(halt),
        .Retire(retire), .BranchTaken(branch_taken), .PcLoad(s_pcl), .PcLoadVal(s_pcv),
        .Run(s_run), .Ack(s_ack), .Timeout(s_tmo), .CycleCt(s_cyc), .InstCt(s_inst),
        .BranchCt(s_br), .CtOvf(s_ovf)
    );

    typedef struct {
        logic        pcl, run, ack, tmo, ovf;
        logic [9:0]  pcv;
        logic [15:0] cyc, inst, br;
    } obs_t;

    typedef struct {
        int cyc, inst, br;
        bit tmo, ovf;
    } res_t;

    int   cw_c  [3] = '{16, 16, 4};
    int   tmo_c [3] = '{4096, 8, 0};
    res_t exp_q [3][$];
    res_t last_res [3];
    bit   last_valid [3];
    bit   r_q[$], b_q[$], h_q[$];
    int   n_checks = 0;
    int   n_bad    = 0;
    logic prev_ack [3];

    function automatic obs_t obs(input int i);
        obs_t o;
        case (i)
            0: begin
                o.pcl = a_pcl; o.run = a_run; o.ack = a_ack; o.tmo = a_tmo; o.ovf = a_ovf;
                o.pcv = a_pcv; o.cyc = a_cyc; o.inst = a_inst; o.br = a_br;
            end
            1: begin
                o.pcl = w_pcl; o.run = w_run; o.ack = w_ack; o.tmo = w_tmo; o.ovf = w_ovf;
                o.pcv = w_pcv; o.cyc = w_cyc; o.inst = w_inst; o.br = w_br;
            end
            default: begin
                o.pcl = s_pcl; o.run = s_run; o.ack = s_ack; o.tmo = s_tmo; o.ovf = s_ovf;
                o.pcv = s_pcv; o.cyc = 16'(s_cyc); o.inst = 16'(s_inst); o.br = 16'(s_br);
            end
        endcase
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a run ends at the first halt, or when the (saturating) cycle count
    // first equals the watchdog limit; counts are plain tallies clipped at the counter max.
    task automatic model_push();
        int n = r_q.size();
        for (int i = 0; i < 3; i++) begin
            int   maxv = (1 << cw_c[i]) - 1;
            int   stop = 0;
            bit   halted = 0;
            int   ni = 0;
            int   nb = 0;
            res_t res;
            for (int k = 0; k < n; k++) begin
                if (h_q[k]) begin
                    stop = k + 1;
                    halted = 1;
                    break;
                end else if (tmo_c[i] != 0 && tmo_c[i] <= maxv && k + 1 == tmo_c[i]) begin
                    stop = k + 1;
                    break;
                end
            end
            last_valid[i] = (stop != 0);
            if (stop != 0) begin
                for (int k = 0; k < stop; k++) begin
                    if (r_q[k]) ni++;
                    if (r_q[k] && b_q[k]) nb++;
                end
                res.cyc  = (stop > maxv) ? maxv : stop;
                res.inst = (ni > maxv) ? maxv : ni;
                res.br   = (nb > maxv) ? maxv : nb;
                res.ovf  = (stop > maxv) || (ni > maxv) || (nb > maxv);
                res.tmo  = !halted;
                exp_q[i].push_back(res);
                last_res[i] = res;
            end
        end
    endtask

    task automatic clear_stim();
        r_q.delete();
        b_q.delete();
        h_q.delete();
    endtask

    task automatic run_prog(input logic [9:0] addr, input int arm);
        obs_t o;
        model_push();
        start = 1'b1;
        start_addr = addr;
        for (int a = 0; a < arm; a++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                o = obs(i);
                check($sformatf("dut%0d arm pcload", i), o.pcl, 1);
                check($sformatf("dut%0d arm pcloadval", i), o.pcv, addr);
                check($sformatf("dut%0d arm counters", i), {o.cyc, o.inst, o.br}, 0);
                check($sformatf("dut%0d arm flags", i), {o.ack, o.tmo, o.ovf, o.run}, 0);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            o = obs(i);
            check($sformatf("dut%0d run entry", i), {o.pcl, o.run, o.pcv}, {2'b01, addr});
        end
        for (int k = 0; k < r_q.size(); k++) begin
            retire = r_q[k];
            branch_taken = b_q[k];
            halt = h_q[k];
            @(posedge clk); #1;
        end
        retire = 1'b0;
        branch_taken = 1'b0;
        halt = 1'b0;
    endtask

    task automatic pop_check(input int i);
        obs_t o = obs(i);
        res_t e;
        check($sformatf("dut%0d ack expected", i), exp_q[i].size() != 0, 1);
        if (exp_q[i].size() != 0) begin
            e = exp_q[i].pop_front();
            check($sformatf("dut%0d done cycle_ct", i), o.cyc, e.cyc);
            check($sformatf("dut%0d done inst_ct", i), o.inst, e.inst);
            check($sformatf("dut%0d done branch_ct", i), o.br, e.br);
            check($sformatf("dut%0d done timeout", i), o.tmo, e.tmo);
            check($sformatf("dut%0d done ct_ovf", i), o.ovf, e.ovf);
            check($sformatf("dut%0d done run", i), o.run, 0);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && obs(i).ack && !prev_ack[i]) pop_check(i);
            prev_ack[i] <= obs(i).ack;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        obs_t o;
        rst_n = 1'b0;
        start = 1'b0;
        start_addr = '0;
        halt = 1'b0;
        retire = 1'b0;
        branch_taken = 1'b0;
        #12;
        for (int i = 0; i < 3; i++) begin
            o = obs(i);
            check($sformatf("dut%0d reset state", i),
                  {o.pcl, o.run, o.ack, o.tmo, o.ovf, o.pcv, o.cyc, o.inst, o.br}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic run: retire every cycle, halt on the 6th RUN cycle.
        clear_stim();
        for (int k = 0; k < 6; k++) begin
            r_q.push_back(1); b_q.push_back(0); h_q.push_back(k == 5);
        end
        run_prog(10'h020, 3);

        // Inputs toggling after DONE must leave everything untouched.
        repeat (10) begin
            retire = 1'($urandom_range(0, 1));
            halt = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        retire = 1'b0; halt = 1'b0; branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (last_valid[i]) begin
                o = obs(i);
                check($sformatf("dut%0d post-done counters", i), {o.cyc, o.inst, o.br},
                      {16'(last_res[i].cyc), 16'(last_res[i].inst), 16'(last_res[i].br)});
                check($sformatf("dut%0d post-done ack", i), {o.ack, o.run}, 2'b10);
            end
        end

        // Branch counting: retire on even cycles, branch on 2..4, halt on 10.
        clear_stim();
        for (int k = 1; k <= 10; k++) begin
            r_q.push_back(k % 2 == 0); b_q.push_back(k >= 2 && k <= 4); h_q.push_back(k == 10);
        end
        run_prog(10'h0a5, 2);

        // Long run: dut_w times out at 8 and stays frozen; dut_s saturates.
        clear_stim();
        for (int k = 1; k <= 28; k++) begin
            r_q.push_back(1); b_q.push_back(1'($urandom_range(0, 1))); h_q.push_back(k == 28);
        end
        run_prog(10'h3ff, 1);
        o = obs(1);
        check("dut1 frozen after timeout", {o.cyc, o.inst, o.ack, o.tmo, o.run},
              {16'd8, 16'd8, 3'b110});

        // Halt on the 8th cycle beats the watchdog.
        clear_stim();
        for (int k = 1; k <= 8; k++) begin
            r_q.push_back(1); b_q.push_back(0); h_q.push_back(k == 8);
        end
        run_prog(10'h100, 2);

        // Restart during RUN after five cycles.
        clear_stim();
        for (int k = 1; k <= 5; k++) begin
            r_q.push_back(1'($urandom_range(0, 1))); b_q.push_back(1); h_q.push_back(0);
        end
        run_prog(10'h077, 2);
        o = obs(0);
        check("dut0 cycles before restart", {o.cyc, o.ack, o.run}, {16'd5, 2'b01});
        clear_stim();
        for (int k = 1; k <= 4; k++) begin
            r_q.push_back(1); b_q.push_back(0); h_q.push_back(k == 4);
        end
        run_prog(10'h155, 2);

        // Randomized programs.
        repeat (25) begin
            int n = $urandom_range(1, 30);
            clear_stim();
            for (int k = 0; k < n; k++) begin
                r_q.push_back(1'($urandom_range(0, 1)));
                b_q.push_back(1'($urandom_range(0, 1)));
                h_q.push_back($urandom_range(0, 24) == 0);
            end
            if ($urandom_range(0, 3) != 0) h_q[n-1] = 1'b1;
            run_prog(10'($urandom), $urandom_range(1, 4));
        end

        // Asynchronous reset in the middle of a run.
        clear_stim();
        for (int k = 0; k < 3; k++) begin
            r_q.push_back(1); b_q.push_back(1); h_q.push_back(0);
        end
        run_prog(10'h2aa, 1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            o = obs(i);
            check($sformatf("dut%0d async reset", i),
                  {o.pcl, o.run, o.ack, o.tmo, o.ovf, o.pcv, o.cyc, o.inst, o.br}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        o = obs(0);
        check("dut0 idle after reset", {o.pcl, o.run, o.pcv, o.cyc}, 0);

        clear_stim();
        for (int k = 1; k <= 4; k++) begin
            r_q.push_back(1); b_q.push_back(k == 2); h_q.push_back(k == 4);
        end
        run_prog(10'h011, 2);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("dut%0d results outstanding", i), exp_q[i].size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Parametrised run controller and performance-counter block for the basic processor.
- Owns the Start/Ack program-run handshake and loads the start address into instruction fetch.
- Gates core execution and counts cycles, retired instructions and taken branches.
- Adds restart, a watchdog timeout and counter-saturation reporting.
- Sits between the testbench Start/Ack pins and InstFetch/Ctrl, replacing the free-standing cycle counter.

Parameters:
- AW, 10: program-counter / start-address width.
- CW, 16: width of each performance counter.
- TMO_CYC, 4096: watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
- Clk, in, 1: clock, posedge.
- Reset, in, 1: asynchronous, active-low reset.
- Start, in, 1: level; high = hold/arm program, falling edge (high then low) launches it.
- StartAddr, in, AW: PC value loaded while armed.
- Halt, in, 1: decoder reports the halt instruction at the current PC.
- Retire, in, 1: one instruction completes this cycle.
- BranchTaken, in, 1: the retiring instruction redirected the PC. Qualified by Retire.
- PcLoad, out, 1: force the PC to PcLoadVal.
- PcLoadVal, out, AW: registered copy of StartAddr.
- Run, out, 1: core may advance the PC and commit state.
- Ack, out, 1: program finished (halt or timeout).
- Timeout, out, 1: finish was caused by the watchdog.
- CycleCt, out, CW: RUN cycles.
- InstCt, out, CW: retired instructions.
- BranchCt, out, CW: taken branches.
- CtOvf, out, 1: sticky; any counter saturated.

Behaviour:
- All outputs are registered.
- Reset low, asynchronously: state = IDLE, every output and counter = 0.
- States: IDLE, ARM, RUN, DONE, TMO.
- IDLE:
  - Run = 0, Ack = 0.
  - Start = 1 -> ARM.
- ARM:
  - Every cycle: PcLoad = 1, PcLoadVal <= StartAddr.
  - All counters, CtOvf, Ack and Timeout are cleared.
  - Run = 0.
  - Start = 0 -> RUN on the next edge; PcLoad drops in that same transition.
- RUN:
  - Run = 1.
  - CycleCt += 1 every cycle.
  - InstCt += 1 when Retire = 1.
  - BranchCt += 1 when Retire = 1 and BranchTaken = 1. BranchTaken without Retire is ignored.
- Halt in RUN:
  - Halt = 1 in RUN -> DONE. That cycle is still counted, including any Retire or BranchTaken.
  - Ack rises on the edge that enters DONE, i.e. one cycle after Halt is sampled.
- Watchdog:
  - Applies when TMO_CYC != 0, in RUN, with Halt = 0.
  - If the CycleCt value being written equals TMO_CYC -> TMO, with Ack = 1 and Timeout = 1.
  - Halt and the timeout condition in the same cycle: Halt wins, Timeout = 0.
- DONE / TMO:
  - Run = 0; counters frozen; Ack (and Timeout in TMO) held.
  - Start = 1 -> ARM, which clears Ack and Timeout.
- Start = 1 while in RUN: abort and restart -> ARM next edge. Counters clear, Ack stays 0.
- Saturation: each counter stops at all-ones (2^CW-1). CtOvf is set on the attempted increment beyond that and stays set until ARM.
- Retire, Halt and BranchTaken are ignored outside RUN.
- StartAddr is sampled only in ARM.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0. A new Start is required.
- No combinational path from any input to any output.

Test Plan:
- Basic run:
  - Stimulus: reset; Start high 3 cycles with StartAddr = 10'h020, then low; Retire every cycle; Halt on the 6th RUN cycle.
  - Response: PcLoad = 1 for 3 cycles with PcLoadVal = 020, then Ack = 1 one cycle after Halt. CycleCt = 6, InstCt = 6, Timeout = 0.
- Branch counting:
  - Stimulus: 10 RUN cycles, Retire on even cycles, BranchTaken = 1 on cycles 2, 3 and 4 (cycle 3 has no Retire); Halt on cycle 10.
  - Response: InstCt = 5, BranchCt = 2.
- Watchdog:
  - Stimulus: TMO_CYC = 8, no Halt.
  - Response: TMO after CycleCt = 8; Ack = 1, Timeout = 1, Run = 0; counters frozen for 20 further cycles.
  - Stimulus: Halt on the 8th cycle instead.
  - Response: DONE with Timeout = 0.
- Restart and reset:
  - Stimulus: Start pulse during RUN at CycleCt = 5.
  - Response: ARM, counters = 0, new StartAddr loaded, Ack never asserted.
  - Stimulus: Reset low mid-RUN, asynchronous with respect to Clk.
  - Response: all outputs 0 before the next edge; state IDLE.
- Saturation:
  - Stimulus: CW = 4, TMO_CYC = 0, Retire every cycle for 20 cycles.
  - Response: CycleCt = InstCt = 4'hF, CtOvf = 1; next ARM clears CtOvf.
- Post-DONE:
  - Stimulus: after DONE, toggle Retire, Halt and BranchTaken for 10 cycles.
  - Response: counters and Ack unchanged; Start then returns to ARM with Ack = 0.
